// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_e;

endpackage

// File: rtl/ahb_sram_bank.sv
// DEPTH x DATA_W memory with per-byte write enables, one write and one registered read per cycle.
module ahb_sram_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);
  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Read returns the pre-write word on a same-address collision; the top merges.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: address-phase decode, wait-state/error FSM, byte strobes, RAW forwarding.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp
);
  localparam int          BYTES     = DATA_W / 8;
  localparam int          LANE_W    = $clog2(BYTES);
  localparam int          IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(BYTES);
  localparam logic [3:0]  WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slv_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              dp_valid_q, dp_valid_d, dp_write_q, dp_write_d;
  logic [IDX_W-1:0]  dp_idx_q, dp_idx_d;
  logic [BYTES-1:0]  dp_strb_q, dp_strb_d;
  logic              rd_valid_q, rd_valid_d, raw_q, raw_d;
  logic [DATA_W-1:0] raw_wdata_q, raw_wdata_d;
  logic [BYTES-1:0]  raw_strb_q, raw_strb_d;

  logic              ready, accept, err, wr_commit, rd_en;
  logic [LANE_W-1:0] off;
  logic [7:0]        amask;
  logic [IDX_W-1:0]  idx, rd_idx;
  logic [BYTES-1:0]  strb;
  logic [DATA_W-1:0] bank_rdata;
  logic              unused_inputs;

  assign unused_inputs = ^{hburst, hprot, htrans[0]};

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign accept = hsel && hready && htrans[1] && ready;

  always_comb begin
    off   = haddr[LANE_W-1:0];
    idx   = haddr[LANE_W +: IDX_W];
    amask = (8'd1 << hsize) - 8'd1;
    err   = (64'(haddr) >= MEM_BYTES) || (hsize > 3'(LANE_W)) || (|(8'(off) & amask));
    strb  = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (i >= 32'(off) && i < 32'(off) + (32'd1 << hsize)) strb[i] = 1'b1;
    end
  end

  // A data phase only completes (and a write commits) in a ready state.
  assign wr_commit = dp_valid_q && dp_write_q && ready && hresetn;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    dp_strb_d  = dp_strb_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d    = ST_IDLE;
        dp_valid_d = 1'b0;
        if (accept) begin
          dp_valid_d = !err;
          dp_write_d = hwrite;
          dp_idx_d   = idx;
          dp_strb_d  = strb;
          if (err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
    endcase
  end

  // Zero-wait reads sample at the accept edge; otherwise on the last wait cycle.
  always_comb begin
    if (WAIT_STATES == 0) begin
      rd_en  = accept && !hwrite && !err;
      rd_idx = idx;
    end else begin
      rd_en  = (state_q == ST_WAIT) && (cnt_q == '0) && dp_valid_q && !dp_write_q;
      rd_idx = dp_idx_q;
    end
    rd_valid_d  = rd_en;
    raw_d       = rd_en && wr_commit && (rd_idx == dp_idx_q);
    raw_wdata_d = hwdata;
    raw_strb_d  = dp_strb_q;
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_idx_q    <= '0;
      dp_strb_q   <= '0;
      rd_valid_q  <= 1'b0;
      raw_q       <= 1'b0;
      raw_wdata_q <= '0;
      raw_strb_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_idx_q    <= dp_idx_d;
      dp_strb_q   <= dp_strb_d;
      rd_valid_q  <= rd_valid_d;
      raw_q       <= raw_d;
      raw_wdata_q <= raw_wdata_d;
      raw_strb_q  <= raw_strb_d;
    end
  end

  ahb_sram_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH)
  ) u_bank (
    .clk   (hclk),
    .we    (wr_commit),
    .waddr (dp_idx_q),
    .wstrb (dp_strb_q),
    .wdata (hwdata),
    .re    (rd_en),
    .raddr (rd_idx),
    .rdata (bank_rdata)
  );

  always_comb begin
    hrdata = '0;
    if (rd_valid_q) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        hrdata[8*i +: 8] = (raw_q && raw_strb_q[i]) ? raw_wdata_q[8*i +: 8] : bank_rdata[8*i +: 8];
      end
    end
  end

  assign hreadyout = ready;
  assign hresp     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: zero-wait and 3-wait instances against a byte-array model.
module tb_ahb_lite_sram_slave;
  import ahb_lite_pkg::*;

  localparam int DEPTH = 64;
  localparam int NBYTES = DEPTH * 4;
  localparam int K_XFER = 0, K_IDLE = 1, K_BUSY = 2, K_DESEL = 3;

  typedef struct {
    int          kind;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [1:0]  tr;
  } xfer_t;

  logic        hclk = 1'b0, hresetn = 1'b0, hsel0 = 1'b0, hsel3 = 1'b0, hwrite = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic [2:0]  hsize = '0, hburst = '0;
  logic [3:0]  hprot = '0;
  logic        hready, hreadyout0, hreadyout3, hresp0, hresp3, sel3 = 1'b0;
  logic [31:0] hrdata0, hrdata3, hrdata_m;
  logic        hresp_m;

  int checks = 0, failures = 0;
  logic [7:0] mdl [2][NBYTES];
  xfer_t q[$];

  always #5 hclk = ~hclk;

  assign hready   = sel3 ? hreadyout3 : hreadyout0;
  assign hrdata_m = sel3 ? hrdata3 : hrdata0;
  assign hresp_m  = sel3 ? hresp3 : hresp0;

  ahb_lite_sram_slave #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(hready), .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0));

  ahb_lite_sram_slave #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(hready), .hrdata(hrdata3), .hreadyout(hreadyout3), .hresp(hresp3));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, sel3 ? 3 : 0, obs, exp);
    end
  endtask

  function automatic bit exp_err(input xfer_t x);
    return (x.addr >= 32'(NBYTES)) || (x.size > 3'd2) ||
           ((x.addr & ((32'd1 << x.size) - 32'd1)) != 32'd0);
  endfunction

  function automatic logic [31:0] model_word(input bit d, input logic [31:0] a);
    int w = int'(a >> 2);
    return {mdl[d][w*4+3], mdl[d][w*4+2], mdl[d][w*4+1], mdl[d][w*4]};
  endfunction

  task automatic commit(input bit d, input xfer_t x);
    for (int b = 0; b < (1 << x.size); b++) begin
      int a = int'(x.addr) + b;
      mdl[d][a] = x.data[8*(a%4) +: 8];
    end
  endtask

  function automatic xfer_t mk(input int kind, input logic wr, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] data);
    xfer_t x;
    x.kind = kind; x.wr = wr; x.addr = addr; x.size = size; x.data = data; x.tr = HTRANS_NONSEQ;
    return x;
  endfunction

  function automatic xfer_t rnd_xfer();
    xfer_t x;
    int r = $urandom_range(0, 99);
    x.kind = (r < 80) ? K_XFER : (r < 87) ? K_IDLE : (r < 94) ? K_BUSY : K_DESEL;
    x.wr   = 1'($urandom_range(0, 1));
    x.size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    r = $urandom_range(0, 19);
    x.addr = (r == 0) ? 32'h8000_0010 : (r == 1) ? 32'($urandom_range(NBYTES, NBYTES + 40))
                                                  : 32'($urandom_range(0, NBYTES - 1));
    if ($urandom_range(0, 3) != 0) x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
    x.data = $urandom;
    x.tr   = $urandom_range(0, 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
    return x;
  endfunction

  task automatic drive_addr(input xfer_t x);
    haddr = x.addr; hwrite = x.wr; hsize = x.size; hburst = 3'd0; hprot = 4'd3;
    hsel0 = 1'b0; hsel3 = 1'b0;
    case (x.kind)
      K_XFER:  htrans = x.tr;
      K_BUSY:  htrans = HTRANS_BUSY;
      K_DESEL: htrans = HTRANS_NONSEQ;
      default: htrans = HTRANS_IDLE;
    endcase
    if (x.kind != K_DESEL) begin hsel0 = !sel3; hsel3 = sel3; end
  endtask

  // Pipelined master: address of the next item overlaps the data phase of the current one.
  task automatic run_queue();
    int ai = 0, waits = 0, guard = 0, limit;
    bit have_dp = 0, rdy, e;
    xfer_t cur, idle_x;
    idle_x = mk(K_IDLE, 1'b0, 32'd0, 3'd2, 32'd0);
    limit  = 20 * q.size() + 20;
    while (ai < q.size() || have_dp) begin
      drive_addr((ai < q.size()) ? q[ai] : idle_x);
      hwdata = (have_dp && cur.kind == K_XFER && cur.wr) ? cur.data : $urandom;
      @(negedge hclk);
      rdy = hready;
      if (have_dp) begin
        e = (cur.kind == K_XFER) && exp_err(cur);
        check("hresp", 64'(hresp_m), 64'(e));
        if (e) check("err_hrdata", 64'(hrdata_m), 64'd0);
        if (rdy) begin
          if (cur.kind == K_XFER) begin
            check("wait_cycles", 64'(waits), e ? 64'd1 : (sel3 ? 64'd3 : 64'd0));
            if (!e && !cur.wr) check("hrdata", 64'(hrdata_m), 64'(model_word(sel3, cur.addr)));
            if (!e && cur.wr) commit(sel3, cur);
          end else begin
            check("idle_waits", 64'(waits), 64'd0);
          end
        end else begin
          waits++;
        end
      end
      @(posedge hclk); #1;
      if (rdy) begin
        have_dp = (ai < q.size());
        if (have_dp) begin cur = q[ai]; ai++; waits = 0; end
      end
      guard++;
      if (guard > limit) begin
        check("cycle_budget", 64'(guard), 64'(limit));
        break;
      end
    end
    drive_addr(idle_x);
    q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge hclk);
    check({tag, "_hreadyout"}, 64'(hready), 64'd1);
    check({tag, "_hresp"}, 64'(hresp_m), 64'd0);
    check({tag, "_hrdata"}, 64'(hrdata_m), 64'd0);
    @(posedge hclk); #1;
  endtask

  task automatic reset_mid_write(input logic [31:0] a);
    drive_addr(mk(K_XFER, 1'b1, a, 3'd2, 32'd0));
    @(posedge hclk); #1;
    drive_addr(mk(K_IDLE, 1'b0, 32'd0, 3'd2, 32'd0));
    hwdata = ~model_word(sel3, a);
    if (sel3) begin @(posedge hclk); #1; end
    hresetn = 1'b0;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    check_idle_outputs("post_reset");
    q.push_back(mk(K_XFER, 1'b0, a, 3'd2, 32'd0));
    run_queue();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
    sel3 = 1'b0; check_idle_outputs("reset");
    sel3 = 1'b1; check_idle_outputs("reset");

    for (int d = 0; d < 2; d++) begin
      sel3 = d[0];
      for (int w = 0; w < DEPTH; w++) q.push_back(mk(K_XFER, 1'b1, 32'(w * 4), 3'd2, $urandom));
      run_queue();

      q.push_back(mk(K_XFER, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
      q.push_back(mk(K_IDLE, 1'b0, 32'h0, 3'd2, 32'h0));
      q.push_back(mk(K_XFER, 1'b0, 32'h10, 3'd2, 32'h0));
      q.push_back(mk(K_XFER, 1'b1, 32'h20, 3'd2, 32'h11223344));
      q.push_back(mk(K_XFER, 1'b1, 32'h21, 3'd0, 32'h5555AA55));
      q.push_back(mk(K_BUSY, 1'b0, 32'h0, 3'd2, 32'h0));
      q.push_back(mk(K_XFER, 1'b0, 32'h20, 3'd2, 32'h0));
      q.push_back(mk(K_XFER, 1'b0, 32'(NBYTES), 3'd2, 32'h0));
      q.push_back(mk(K_XFER, 1'b1, 32'h3, 3'd1, 32'hCAFEF00D));
      q.push_back(mk(K_XFER, 1'b1, 32'(NBYTES), 3'd2, 32'h12345678));
      q.push_back(mk(K_XFER, 1'b0, 32'h0, 3'd2, 32'h0));
      q.push_back(mk(K_XFER, 1'b1, 32'h40, 3'd2, 32'hA5A5_5A5A));
      q.push_back(mk(K_XFER, 1'b0, 32'h40, 3'd2, 32'h0));
      q.push_back(mk(K_XFER, 1'b1, 32'h42, 3'd1, 32'h7788_0000));
      q.push_back(mk(K_XFER, 1'b0, 32'h40, 3'd2, 32'h0));
      q.push_back(mk(K_DESEL, 1'b1, 32'h40, 3'd2, 32'hFFFF_FFFF));
      q.push_back(mk(K_XFER, 1'b0, 32'h40, 3'd2, 32'h0));
      run_queue();

      reset_mid_write(32'h30);

      for (int n = 0; n < 200; n++) begin
        xfer_t x = rnd_xfer();
        q.push_back(x);
        if (x.kind == K_XFER && x.wr && !exp_err(x) && $urandom_range(0, 3) == 0)
          q.push_back(mk(K_XFER, 1'b0, x.addr & ~32'd3, 3'd2, 32'h0));
      end
      run_queue();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
